// File: rtl/led_pattern_engine.sv
// led_pattern_engine: running-light generator for a WIDTH-wide LED bar.
// Modes DOT / BOUNCE / BAR / INV_DOT, dir mirroring, div+1 step prescaler,
// play/pause, sync restart, one-cycle wrap pulse per pattern period.
// Optional build macro LED_PWM_EN adds 4-bit PWM brightness gating via duty.
module led_pattern_engine #(
  parameter int WIDTH = 16,
  parameter int DIV_W = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             play_pause,
  input  logic             restart,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [DIV_W-1:0] div,
  input  logic [3:0]       duty,
  output logic [WIDTH-1:0] led,
  output logic             wrap
);

  localparam int             PW   = $clog2(WIDTH);
  localparam logic [PW-1:0]  LAST = PW'(WIDTH - 1);
  localparam logic [1:0]     MODE_DOT    = 2'd0;
  localparam logic [1:0]     MODE_BOUNCE = 2'd1;
  localparam logic [1:0]     MODE_BAR    = 2'd2;

  typedef enum logic {FWD = 1'b0, BACK = 1'b1} head_t;

  head_t            head, head_nx;
  logic [PW-1:0]    pos, pos_nx;
  logic [DIV_W-1:0] presc, presc_nx;
  logic [1:0]       mode_q;
  logic             init;
  logic             wrap_nx;
  logic             resync;
  logic             tick;
  logic [WIDTH-1:0] pat_nx, led_nx;
  int               idx, bidx;

  // The first edge after reset behaves like a restart so it loads pattern(0)
  // instead of stepping; a mode change also forces the sweep back to start.
  assign resync = init | restart | (mode != mode_q);
  assign tick   = play_pause & (presc >= div);

  // State register: position, heading, prescaler and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head   <= FWD;
      pos    <= '0;
      presc  <= '0;
      mode_q <= '0;
      init   <= 1'b1;
      led    <= {1'b1, {(WIDTH-1){1'b0}}};
      wrap   <= 1'b0;
    end else begin
      head   <= head_nx;
      pos    <= pos_nx;
      presc  <= presc_nx;
      mode_q <= mode;
      init   <= 1'b0;
      led    <= led_nx;
      wrap   <= wrap_nx;
    end
  end

  // Next-state: resync beats tick; pause holds everything including presc.
  always_comb begin
    pos_nx   = pos;
    head_nx  = head;
    presc_nx = presc;
    wrap_nx  = 1'b0;
    if (resync) begin
      pos_nx   = '0;
      head_nx  = FWD;
      presc_nx = '0;
    end else if (play_pause) begin
      if (!tick) begin
        presc_nx = presc + 1'b1;
      end else begin
        presc_nx = '0;
        if (mode == MODE_BOUNCE) begin
          if (head == FWD) begin
            if (pos == LAST) begin
              head_nx = BACK;
              pos_nx  = pos - 1'b1;
            end else begin
              pos_nx  = pos + 1'b1;
            end
          end else begin
            // Leaving the start end closes one full bounce period.
            if (pos == '0) begin
              head_nx = FWD;
              pos_nx  = pos + 1'b1;
              wrap_nx = 1'b1;
            end else begin
              pos_nx  = pos - 1'b1;
            end
          end
        end else if (pos == LAST) begin
          pos_nx  = '0;
          wrap_nx = 1'b1;
        end else begin
          pos_nx  = pos + 1'b1;
        end
      end
    end
  end

  // Output decode: pattern from the next position so led and pos move together.
  always_comb begin
    idx    = dir ? int'(pos_nx) : WIDTH - 1 - int'(pos_nx);
    bidx   = WIDTH - 1 - int'(pos_nx);
    pat_nx = '0;
    for (int k = 0; k < WIDTH; k++) begin
      case (mode)
        MODE_DOT:    pat_nx[k] = (k == idx);
        MODE_BOUNCE: pat_nx[k] = (k == bidx);
        MODE_BAR:    pat_nx[k] = dir ? (k <= idx) : (k >= idx);
        default:     pat_nx[k] = (k != idx);
      endcase
    end
  end

`ifdef LED_PWM_EN
  logic [3:0] pwm_cnt;
  logic       pwm_on;

  // Free-running PWM phase counter; only gates the LED drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign pwm_on = (duty == 4'hF) | (pwm_cnt < duty);
  assign led_nx = pat_nx & {WIDTH{pwm_on}};
`else
  // Without PWM the brightness input has no effect.
  logic unused_duty;
  assign unused_duty = ^duty;
  assign led_nx      = pat_nx;
`endif

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine: directed scenarios plus a
// randomized run, all compared against a step-count based reference model.
module tb_led_pattern_engine;
  localparam int W  = 16;
  localparam int DW = 27;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          play_pause;
  logic          restart;
  logic [1:0]    mode;
  logic          dir;
  logic [DW-1:0] div;
  logic [3:0]    duty;
  logic [W-1:0]  led;
  logic          wrap;

  int errors = 0;
  int checks = 0;

  // Reference model: number of steps since the last (re)start, prescaler count.
  int           m_k;
  int           m_presc;
  logic [1:0]   m_mode;
  bit           m_init;
  logic [W-1:0] m_led;
  logic         m_wrap;
  logic [3:0]   m_pwm;

  led_pattern_engine #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .play_pause(play_pause), .restart(restart),
    .mode(mode), .dir(dir), .div(div), .duty(duty), .led(led), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic int model_pos(int k, logic [1:0] md);
    int m;
    if (md == 2'd1) begin
      m = k % (2*W - 2);
      return (m < W) ? m : 2*W - 2 - m;
    end
    return k % W;
  endfunction

  function automatic logic [W-1:0] model_pat(int p, logic [1:0] md, logic d);
    logic [W-1:0] one, b;
    int i;
    i   = d ? p : W - 1 - p;
    one = W'(1) << i;
    b   = W'(1) << (W - 1 - p);
    case (md)
      2'd0:    return one;
      2'd1:    return b;
      2'd2:    return d ? ((one << 1) - W'(1)) : ~(one - W'(1));
      default: return ~one;
    endcase
  endfunction

  task automatic model_reset();
    m_k = 0; m_presc = 0; m_mode = 2'd0; m_init = 1'b1;
    m_led = {1'b1, {(W-1){1'b0}}}; m_wrap = 1'b0; m_pwm = 4'd0;
  endtask

  task automatic model_edge();
    bit rs;
    rs = m_init || restart || (mode != m_mode);
    m_mode = mode; m_init = 1'b0; m_wrap = 1'b0;
    if (rs) begin
      m_k = 0; m_presc = 0;
    end else if (play_pause) begin
      if (m_presc >= int'(div)) begin
        m_presc = 0;
        m_k++;
        if (mode == 2'd1) m_wrap = (m_k > 1) && (m_k % (2*W - 2) == 1);
        else              m_wrap = (m_k % W == 0);
      end else begin
        m_presc++;
      end
    end
    m_led = model_pat(model_pos(m_k, mode), mode, dir);
`ifdef LED_PWM_EN
    if (!((duty == 4'hF) || (m_pwm < duty))) m_led = '0;
    m_pwm = m_pwm + 4'd1;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; play_pause = 1'b1; restart = 1'b0; mode = 2'd0;
    dir = 1'b0; div = '0; duty = 4'hF;
    model_reset();
    #12;
    checks++;
    if (led !== 16'h8000 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset: led=%h wrap=%b expected led=8000 wrap=0", led, wrap);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_dot();
    int p;
    for (int s = 1; s <= 18; s++) begin
      step();
      p = (s == 1) ? 0 : (s - 1) % W;
      checks++;
      if (led !== (16'h8000 >> p) || wrap !== (s == 17)) begin
        errors++;
        $display("FAIL dot_seq s=%0d: led=%h wrap=%b expected led=%h wrap=%b",
                 s, led, wrap, 16'h8000 >> p, (s == 17));
      end
    end
  endtask

  task automatic test_div_pause();
    logic [W-1:0] held;
    div = 27'd3;
    for (int s = 0; s < 12; s++) begin
      step();
      checks++;
      if (led !== m_led || wrap !== m_wrap) begin
        errors++;
        $display("FAIL div3 s=%0d: led=%h wrap=%b expected led=%h wrap=%b", s, led, wrap, m_led, m_wrap);
      end
    end
    step();
    play_pause = 1'b0;
    held = led;
    for (int s = 0; s < 10; s++) begin
      step();
      checks++;
      if (led !== held || wrap !== 1'b0 || led !== m_led) begin
        errors++;
        $display("FAIL pause s=%0d: led=%h wrap=%b expected led=%h wrap=0", s, led, wrap, held);
      end
    end
    play_pause = 1'b1;
    for (int s = 0; s < 12; s++) begin
      step();
      checks++;
      if (led !== m_led || wrap !== m_wrap) begin
        errors++;
        $display("FAIL resume s=%0d: led=%h wrap=%b expected led=%h wrap=%b", s, led, wrap, m_led, m_wrap);
      end
    end
  endtask

  task automatic test_bounce();
    int wraps = 0;
    mode = 2'd1; div = '0;
    for (int s = 0; s < 65; s++) begin
      step();
      if (wrap === 1'b1) wraps++;
      checks++;
      if (led !== m_led || wrap !== m_wrap) begin
        errors++;
        $display("FAIL bounce s=%0d: led=%h wrap=%b expected led=%h wrap=%b", s, led, wrap, m_led, m_wrap);
      end
    end
    checks++;
    if (wraps != 2) begin
      errors++;
      $display("FAIL bounce_wraps: got %0d expected 2", wraps);
    end
  endtask

  task automatic test_bar_inv();
    mode = 2'd2; dir = 1'b1;
    for (int s = 1; s <= 20; s++) begin
      step();
      checks++;
      if (led !== m_led || wrap !== m_wrap) begin
        errors++;
        $display("FAIL bar s=%0d: led=%h wrap=%b expected led=%h wrap=%b", s, led, wrap, m_led, m_wrap);
      end
      if (s == 1 || s == 2 || s == 16 || s == 17) begin
        checks++;
        if (led !== ((s == 16) ? 16'hFFFF : (s == 2) ? 16'h0003 : 16'h0001) || wrap !== (s == 17)) begin
          errors++;
          $display("FAIL bar_const s=%0d: led=%h wrap=%b", s, led, wrap);
        end
      end
    end
    mode = 2'd3; dir = 1'b0;
    step();
    checks++;
    if (led !== 16'h7FFF || wrap !== 1'b0) begin
      errors++;
      $display("FAIL inv0: led=%h wrap=%b expected led=7fff wrap=0", led, wrap);
    end
    step();
    checks++;
    if (led !== 16'hBFFF) begin
      errors++;
      $display("FAIL inv1: led=%h expected bfff", led);
    end
  endtask

  task automatic test_restart_mode();
    mode = 2'd0; dir = 1'b0; div = '0; play_pause = 1'b1;
    for (int s = 0; s < 10; s++) step();
    checks++;
    if (led !== 16'h0040) begin
      errors++;
      $display("FAIL pos9: led=%h expected 0040", led);
    end
    play_pause = 1'b0; restart = 1'b1;
    step();
    restart = 1'b0;
    checks++;
    if (led !== 16'h8000 || wrap !== 1'b0 || led !== m_led) begin
      errors++;
      $display("FAIL restart_paused: led=%h wrap=%b expected led=8000 wrap=0", led, wrap);
    end
    play_pause = 1'b1;
    for (int s = 0; s < 5; s++) step();
    mode = 2'd2;
    step();
    checks++;
    if (led !== 16'h8000 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL mode_change: led=%h wrap=%b expected led=8000 wrap=0", led, wrap);
    end
  endtask

  task automatic test_dir_change();
    mode = 2'd0;
    for (int s = 0; s < 6; s++) step();
    dir = ~dir;
    for (int s = 0; s < 3; s++) begin
      step();
      checks++;
      if (led !== m_led || wrap !== m_wrap) begin
        errors++;
        $display("FAIL dir_change s=%0d: led=%h wrap=%b expected led=%h wrap=%b", s, led, wrap, m_led, m_wrap);
      end
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 400; s++) begin
      restart    = ($urandom_range(39) == 0);
      play_pause = ($urandom_range(4) != 0);
      duty       = 4'($urandom);
      if ($urandom_range(49) == 0) mode = 2'($urandom);
      if ($urandom_range(29) == 0) dir = ~dir;
      if ($urandom_range(24) == 0) div = DW'($urandom_range(3));
      step();
      checks++;
      if (led !== m_led || wrap !== m_wrap) begin
        errors++;
        $display("FAIL random s=%0d: led=%h wrap=%b expected led=%h wrap=%b", s, led, wrap, m_led, m_wrap);
      end
    end
    restart = 1'b0; play_pause = 1'b1; duty = 4'hF;
  endtask

  task automatic test_async_reset();
    mode = 2'd0; dir = 1'b0; div = '0;
    for (int s = 0; s < 7; s++) step();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (led !== 16'h8000 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: led=%h wrap=%b expected led=8000 wrap=0", led, wrap);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      checks++;
      if (led !== m_led || wrap !== m_wrap) begin
        errors++;
        $display("FAIL post_reset s=%0d: led=%h wrap=%b expected led=%h wrap=%b", s, led, wrap, m_led, m_wrap);
      end
    end
  endtask

`ifdef LED_PWM_EN
  task automatic test_pwm();
    int on;
    logic [3:0] dv [3] = '{4'd4, 4'hF, 4'd0};
    int         ex [3] = '{4, 16, 0};
    mode = 2'd0; dir = 1'b0; restart = 1'b1;
    step();
    restart = 1'b0; play_pause = 1'b0;
    for (int t = 0; t < 3; t++) begin
      duty = dv[t];
      on = 0;
      for (int s = 0; s < 16; s++) begin
        step();
        if (led[15] === 1'b1) on++;
        checks++;
        if (led !== m_led) begin
          errors++;
          $display("FAIL pwm_led duty=%h: led=%h expected %h", duty, led, m_led);
        end
      end
      checks++;
      if (on != ex[t]) begin
        errors++;
        $display("FAIL pwm_count duty=%h: on=%0d expected %0d", duty, on, ex[t]);
      end
    end
    play_pause = 1'b1; duty = 4'hF;
  endtask
`endif

  initial begin
    test_reset();
    test_dot();
    test_div_pause();
    test_bounce();
    test_bar_inv();
    test_restart_mode();
    test_dir_change();
`ifdef LED_PWM_EN
    test_pwm();
`endif
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
